// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// State encoding is fixed: IDLE=0, RUN=1, PAUSE=2, DONE=3.
package timer_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Any digit code above 9 is loaded as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
// The master drives the controls; the slave (the timer) drives the status.
interface bcd_countdown_timer_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  expired;
  logic                  done;

  modport master (
    output load, load_val, start, pause,
    input  count, running, expired, done
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, running, expired, done
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit that counts down 9..0 and wraps to 9 with a borrow.
// Priority: reset > load > dec.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (dec) begin
      r_q <= (r_q == '0) ? 4'd9 : r_q - 4'd1;
    end
  end

  assign q          = r_q;
  assign borrow_out = (r_q == '0) && dec;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with tick prescaler and IDLE/RUN/PAUSE/DONE control.
// All logic runs on clk; the prescaler acts as a clock enable for the digit chain.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_countdown_timer_if.slave    bus
);

  localparam int unsigned CW = BCD_W * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_e          r_state;
  logic [PW-1:0]   r_presc;
  logic            r_running;
  logic            r_expired;
  logic            r_done;

  logic [CW-1:0]   w_count;
  logic [DIGITS:0] w_borrow;
  logic            w_tick;
  logic            w_last_step;

  // Ticks only in RUN when not being paused this cycle; load overrides inside the digits.
  assign w_tick      = (r_state == StRun) && !bus.pause && (r_presc == PW'(TICK_DIV - 1));
  assign w_borrow[0] = w_tick;
  assign w_last_step = (w_count == CW'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .d          (bcd_clamp(bus.load_val[g*BCD_W +: BCD_W])),
      .dec        (w_borrow[g]),
      .q          (w_count[g*BCD_W +: BCD_W]),
      .borrow_out (w_borrow[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.load) begin
        r_state   <= StIdle;
        r_presc   <= '0;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.start && !bus.pause) begin
              if (w_count != '0) begin
                r_state   <= StRun;
                r_presc   <= '0;
                r_running <= 1'b1;
              end else begin
                r_state   <= StDone;
                r_expired <= 1'b1;
                r_done    <= 1'b1;
              end
            end
          end
          StRun: begin
            if (bus.pause) begin
              r_state   <= StPause;
              r_running <= 1'b0;
            end else if (w_tick) begin
              r_presc <= '0;
              if (w_last_step) begin
                r_state   <= StDone;
                r_running <= 1'b0;
                r_expired <= 1'b1;
                r_done    <= 1'b1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          StPause: begin
            if (bus.start && !bus.pause) begin
              r_state   <= StRun;
              r_running <= 1'b1;
            end
          end
          StDone: begin
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.count   = w_count;
  assign bus.running = r_running;
  assign bus.expired = r_expired;
  assign bus.done    = r_done;

endmodule
